// File: rtl/dft_npoint_stream.sv
// Streaming N-point DFT (N=4 or 8): load N real samples, one complex MAC per cycle, stream N bins.
// Optional macro DFT_NORM_SCALE_EN divides forward-transform outputs by N.
module dft_npoint_stream #(
  parameter int DATA_W = 16,
  parameter int N_LOG2 = 2,
  parameter int TW_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inverse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

  localparam int N      = 1 << N_LOG2;
  localparam int PROD_W = DATA_W + TW_W;
  localparam int ACC_W  = DATA_W + TW_W + N_LOG2;

  // round(F/sqrt(2)) via integer square root of 2*F^2, so the 45-degree entry tracks TW_W
  function automatic longint half_root2(input longint f);
    longint t, lo, hi, mid;
    t  = 2 * f * f;
    lo = 0;
    hi = longint'(1) << 31;
    for (int i = 0; i < 40; i++) begin
      if (lo < hi) begin
        mid = (lo + hi + 1) / 2;
        if (mid * mid <= t) lo = mid;
        else                hi = mid - 1;
      end
    end
    return (lo + 1) / 2;
  endfunction

  localparam longint F_VAL = (longint'(1) << (TW_W - 1)) - 1;
  localparam longint H_VAL = half_root2(F_VAL);
  localparam logic signed [TW_W-1:0] TW_P = TW_W'(F_VAL);
  localparam logic signed [TW_W-1:0] TW_H = TW_W'(H_VAL);

  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = -SAT_MAX - ACC_W'(1);
  localparam logic signed [DATA_W-1:0] D_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [N_LOG2-1:0]        LAST_IX = N_LOG2'(N - 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;
  state_t state, state_next;

  logic signed [DATA_W-1:0] x_mem  [N];
  logic signed [DATA_W-1:0] res_re [N];
  logic signed [DATA_W-1:0] res_im [N];
  logic [N_LOG2-1:0]        n_cnt, k_cnt, idx;
  logic                     inv_q;
  logic signed [ACC_W-1:0]  acc_re, acc_im, acc_re_next, acc_im_next;
  logic signed [ACC_W-1:0]  sh_re, sh_im;
  logic signed [PROD_W-1:0] prod_re, prod_im;
  logic signed [TW_W-1:0]   tw_re, tw_s;
  logic signed [DATA_W-1:0] bin_re, bin_im;
  logic                     sat_re, sat_im;
  logic [2:0]               oct;
  logic [7:0]               shift_amt;

  // Both lengths share one 8-entry table in 45-degree steps; N=4 uses every other entry
  assign idx = k_cnt * n_cnt;

  always_comb begin
    oct   = 3'(idx);
    tw_re = '0;
    tw_s  = '0;
    if (N_LOG2 == 2) oct = 3'({idx, 1'b0});
    case (oct)
      3'd0: begin tw_re =  TW_P; tw_s =  '0;   end
      3'd1: begin tw_re =  TW_H; tw_s =  TW_H; end
      3'd2: begin tw_re =  '0;   tw_s =  TW_P; end
      3'd3: begin tw_re = -TW_H; tw_s =  TW_H; end
      3'd4: begin tw_re = -TW_P; tw_s =  '0;   end
      3'd5: begin tw_re = -TW_H; tw_s = -TW_H; end
      3'd6: begin tw_re =  '0;   tw_s = -TW_P; end
      default: begin tw_re = TW_H; tw_s = -TW_H; end
    endcase
  end

  assign prod_re     = x_mem[n_cnt] * tw_re;
  assign prod_im     = x_mem[n_cnt] * tw_s;
  assign acc_re_next = acc_re + ACC_W'(prod_re);
  assign acc_im_next = inv_q ? acc_im + ACC_W'(prod_im) : acc_im - ACC_W'(prod_im);

`ifdef DFT_NORM_SCALE_EN
  assign shift_amt = inv_q ? 8'(TW_W - 1) : 8'(TW_W - 1 + N_LOG2);
`else
  assign shift_amt = 8'(TW_W - 1);
`endif

  assign sh_re  = acc_re_next >>> shift_amt;
  assign sh_im  = acc_im_next >>> shift_amt;
  assign sat_re = (sh_re > SAT_MAX) || (sh_re < SAT_MIN);
  assign sat_im = (sh_im > SAT_MAX) || (sh_im < SAT_MIN);
  assign bin_re = sat_re ? (sh_re[ACC_W-1] ? D_MIN : D_MAX) : sh_re[DATA_W-1:0];
  assign bin_im = sat_im ? (sh_im[ACC_W-1] ? D_MIN : D_MAX) : sh_im[DATA_W-1:0];

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    out_re     = '0;
    out_im     = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && n_cnt == LAST_IX) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (n_cnt == LAST_IX && k_cnt == LAST_IX) state_next = OUTPUT;
      end
      OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (k_cnt == LAST_IX);
        out_re    = res_re[k_cnt];
        out_im    = res_im[k_cnt];
        if (out_ready && k_cnt == LAST_IX) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Counters wrap naturally at N, so each phase hands over with both indices back at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOAD;
      n_cnt    <= '0;
      k_cnt    <= '0;
      inv_q    <= 1'b0;
      acc_re   <= '0;
      acc_im   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x_mem[i]  <= '0;
        res_re[i] <= '0;
        res_im[i] <= '0;
      end
    end else begin
      state <= state_next;
      case (state)
        LOAD: begin
          if (in_valid) begin
            x_mem[n_cnt] <= in_data;
            if (n_cnt == '0) inv_q <= inverse;
            n_cnt <= n_cnt + 1'b1;
          end
        end
        COMPUTE: begin
          n_cnt <= n_cnt + 1'b1;
          if (n_cnt == LAST_IX) begin
            res_re[k_cnt] <= bin_re;
            res_im[k_cnt] <= bin_im;
            if (sat_re || sat_im) overflow <= 1'b1;
            acc_re <= '0;
            acc_im <= '0;
            k_cnt  <= k_cnt + 1'b1;
          end else begin
            acc_re <= acc_re_next;
            acc_im <= acc_im_next;
          end
        end
        OUTPUT: begin
          if (out_ready) k_cnt <= k_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dft_npoint_stream.md
DFT_NPOINT_STREAM -- requirements
Module: dft_npoint_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed two's-complement sample width for input and output.
REQ-002 SHALL have parameter N_LOG2, default 2: log2 of transform length N; legal values 2 (N=4) and 3 (N=8).
REQ-003 SHALL have parameter TW_W, default 16: signed Q1.(TW_W-1) twiddle width; full scale is 2^(TW_W-1)-1.
REQ-004 SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-008 SHALL have port in_data, input, DATA_W: real input sample x[n], in order n=0..N-1.
REQ-009 SHALL have port inverse, input, 1: 0 selects forward transform, 1 selects inverse; sampled with sample n=0.
REQ-010 SHALL have port out_valid, output, 1: out_re and out_im hold bin X[k].
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the current bin.
REQ-012 SHALL have ports out_re and out_im, output, DATA_W each: real and imaginary parts of X[k], in order k=0..N-1.
REQ-013 SHALL have port out_last, output, 1: high with bin k=N-1.
REQ-014 SHALL have port busy, output, 1: high in COMPUTE and OUTPUT states.
REQ-015 SHALL have port overflow, output, 1: sticky flag, set on any output saturation; cleared only by reset.

Function
REQ-016 SHALL implement the FSM LOAD -> COMPUTE -> OUTPUT -> LOAD.
REQ-017 LOAD: in_ready=1; each in_valid&&in_ready cycle stores one sample; after the N-th sample, the next state is COMPUTE.
REQ-018 SHALL latch inverse on the n=0 handshake and hold it for the whole frame; inverse changes mid-frame SHALL be ignored.
REQ-019 COMPUTE: one complex MAC per cycle, iterating n fastest then k, for N*N cycles; in_ready=0.
REQ-020 Twiddle SHALL be a constant table indexed by (k*n) mod N: re=round(F*cos(2*pi*idx/N)), s=round(F*sin(2*pi*idx/N)), where F=2^(TW_W-1)-1; for N=8, 45-degree entries = 23170 at TW_W=16.
REQ-021 Accumulators SHALL be signed, DATA_W+TW_W+N_LOG2 bits wide: acc_re += x*re; acc_im -= x*s for forward, acc_im += x*s for inverse.
REQ-022 Each bin result SHALL be acc >>> (TW_W-1) (arithmetic shift, floor), then saturated to DATA_W; any saturation sets overflow.
REQ-023 Completed bins SHALL be stored in an N-entry result buffer; COMPUTE -> OUTPUT after the last MAC.
REQ-024 OUTPUT: out_valid=1; a bin advances only on out_valid&&out_ready; data SHALL remain stable while out_ready=0.
REQ-025 After the bin k=N-1 handshake, the next state SHALL be LOAD and in_ready SHALL be 1 on the following cycle.
REQ-026 Minimum frame latency, last input handshake to first out_valid: N*N+1 cycles.

Reset
REQ-027 Reset SHALL force LOAD, clear sample/bin counters and accumulators, and drive in_ready=1, out_valid=0, out_last=0, busy=0, overflow=0, out_re=0, out_im=0.
REQ-028 Reset mid-frame (any state) SHALL abort the frame with no further output beats.

Configuration
REQ-029 When macro DFT_NORM_SCALE_EN is defined, the shift SHALL be (TW_W-1+N_LOG2) for forward frames only (output divided by N); inverse frames are unchanged.
REQ-030 When DFT_NORM_SCALE_EN is undefined, the shift SHALL be (TW_W-1) for both directions.

Verification (N=4, DATA_W=16, TW_W=16, macro off unless noted)
REQ-031 Impulse x=[32767,0,0,0] forward -> all bins re=32766, im=0; overflow=0.
REQ-032 x=[0,1000,0,0] forward -> X1 = (0,-1000), X3 = (0,999); same frame inverse -> X1 = (0,999), X3 = (0,-1000).
REQ-033 x=[1000,1000,1000,1000] -> X0 = (3999,0), others (0,0); with DFT_NORM_SCALE_EN -> X0 = (999,0).
REQ-034 x=[30000,30000,30000,30000] -> X0.re=32767, overflow=1 and stays 1 over next frame of zeros.
REQ-035 out_ready held low 5 cycles at bin 1 -> out_re/out_im/out_last stable, no bin skipped, out_last only on bin 3.
REQ-036 Reset asserted during COMPUTE -> next cycle out_valid=0, busy=0, in_ready=1; following frame correct.
